pl_reg_elastic: RTL and testbench

Parametrised elastic pipeline stage register, the successor to the fixed decode/execute register. It carries a control field and a data field between any two pipeline stages using a valid/ready handshake. A two-entry skid buffer gives full throughput with a registered in_ready, so backpressure never forms a combinational path through the stage. Supports synchronous flush with bubble semantics: control bits read as zero whenever no valid entry is presented.

---
 rtl/pl_reg_elastic.sv | 135 +++++++++++++
 tb/tb_pl_reg_elastic.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pl_reg_elastic.sv
// Elastic pipeline stage register: two-entry skid buffer, registered in_ready.
// Optional saturating stall/flush counters with `define PL_REG_STATS_EN.
module pl_reg_elastic #(
   parameter int CTRL_W = 12,
   parameter int DATA_W = 160,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data
`ifdef PL_REG_STATS_EN
   ,
   output logic [STAT_W-1:0] stall_cnt,
   output logic [STAT_W-1:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t state, state_nx;

   logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
   logic [DATA_W-1:0] main_data, skid_data;
   logic in_xfer, out_xfer;
   logic load_main_in, load_main_skid, load_skid;

   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;
   assign out_valid = (state != EMPTY);
   assign out_ctrl  = out_valid ? main_ctrl : '0;
   assign out_data  = main_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= EMPTY;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx       = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_nx = EMPTY;
      end else begin
         unique case (state)
            EMPTY: begin
               if (in_xfer) begin
                  state_nx     = ONE;
                  load_main_in = 1'b1;
               end
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  load_main_in = 1'b1;
               end else if (in_xfer) begin
                  state_nx  = TWO;
                  load_skid = 1'b1;
               end else if (out_xfer) begin
                  state_nx = EMPTY;
               end
            end
            TWO: begin
               if (out_xfer) begin
                  state_nx       = ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: state_nx = EMPTY;
         endcase
      end
   end

   // Registered ready: looks one edge ahead so backpressure stays flop-bounded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) in_ready <= 1'b0;
      else     in_ready <= (state_nx != TWO);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_ctrl <= '0;
         main_data <= '0;
         skid_ctrl <= '0;
         skid_data <= '0;
      end else if (flush) begin
         main_ctrl <= '0;
         main_data <= '0;
         skid_ctrl <= '0;
         skid_data <= '0;
      end else begin
         if (load_main_in) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
         end else if (load_main_skid) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
         end
         if (load_skid) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
         end
      end
   end

`ifdef PL_REG_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + STAT_W'(1);
         if (flush && state != EMPTY && flush_cnt != '1)
            flush_cnt <= flush_cnt + STAT_W'(1);
      end
   end
`else
   logic [31:0] unused_stat_w;
   assign unused_stat_w = 32'(STAT_W);
`endif

endmodule

// File: tb/tb_pl_reg_elastic.sv
// Randomized and directed bench for pl_reg_elastic against a queue model.
// Stats checks are compiled in when PL_REG_STATS_EN is defined.
module tb_pl_reg_elastic;

   localparam int CW = 12;
   localparam int DW = 160;
   localparam int SW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_ctrl;
   logic [DW-1:0] out_data;

   always #5 clk = ~clk;

`ifdef PL_REG_STATS_EN
   logic [SW-1:0] stall_cnt, flush_cnt;
   logic          s_in_ready, s_out_valid;
   logic [CW-1:0] s_out_ctrl;
   logic [DW-1:0] s_out_data;
   logic [1:0]    s_stall_cnt, s_flush_cnt;

   pl_reg_elastic #(.CTRL_W(CW), .DATA_W(DW), .STAT_W(SW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ctrl(out_ctrl), .out_data(out_data),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pl_reg_elastic #(.CTRL_W(CW), .DATA_W(DW), .STAT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(s_out_valid), .out_ready(out_ready),
      .out_ctrl(s_out_ctrl), .out_data(s_out_data),
      .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );
`else
   pl_reg_elastic #(.CTRL_W(CW), .DATA_W(DW), .STAT_W(SW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ctrl(out_ctrl), .out_data(out_data)
   );
`endif

   typedef struct {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } ent_t;

   ent_t q[$];
   bit   exp_rdy;
   bit   last_acc;
   longint unsigned m_stall, m_flush;
   int   checks = 0;
   int   passed = 0;

   function automatic logic [DW-1:0] rdata();
      return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic longint unsigned sat(longint unsigned v, int w);
      longint unsigned mx;
      mx = (64'd1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      q.delete();
      exp_rdy = 1'b0;
      m_stall = 0;
      m_flush = 0;
   endtask

   task automatic push(input logic [CW-1:0] c);
      in_valid = 1'b1;
      in_ctrl  = c;
      in_data  = rdata();
   endtask

   // Check all outputs against the model, then advance one clock.
   task automatic step(input string tag);
      logic [CW-1:0] ec;
      bit ox, ix;
      ent_t e;
      ec = (q.size() != 0) ? q[0].c : '0;
      checks++;
      if (out_valid !== (q.size() != 0))
         $display("FAIL %s out_valid got %b want %b", tag, out_valid, q.size() != 0);
      else passed++;
      checks++;
      if (out_ctrl !== ec)
         $display("FAIL %s out_ctrl got %h want %h", tag, out_ctrl, ec);
      else passed++;
      if (q.size() != 0) begin
         checks++;
         if (out_data !== q[0].d)
            $display("FAIL %s out_data got %h want %h", tag, out_data, q[0].d);
         else passed++;
      end
      checks++;
      if (in_ready !== exp_rdy)
         $display("FAIL %s in_ready got %b want %b", tag, in_ready, exp_rdy);
      else passed++;
`ifdef PL_REG_STATS_EN
      checks++;
      if (stall_cnt !== SW'(sat(m_stall, SW)))
         $display("FAIL %s stall_cnt got %0d want %0d", tag, stall_cnt, sat(m_stall, SW));
      else passed++;
      checks++;
      if (flush_cnt !== SW'(sat(m_flush, SW)))
         $display("FAIL %s flush_cnt got %0d want %0d", tag, flush_cnt, sat(m_flush, SW));
      else passed++;
      checks++;
      if (s_stall_cnt !== 2'(sat(m_stall, 2)))
         $display("FAIL %s sat_stall got %0d want %0d", tag, s_stall_cnt, sat(m_stall, 2));
      else passed++;
`endif
      ox = (q.size() != 0) && out_ready;
      ix = in_valid && exp_rdy;
      e.c = in_ctrl;
      e.d = in_data;
      if (q.size() != 0 && !out_ready) m_stall++;
      if (flush && q.size() != 0) m_flush++;
      @(posedge clk);
      if (ox) void'(q.pop_front());
      if (flush) q.delete();
      else if (ix) q.push_back(e);
      last_acc = ix && !flush;
      exp_rdy = (q.size() < 2);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 12'hFFF; in_data = rdata();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0)
         $display("FAIL reset_out got v=%b c=%h want v=0 c=0 d=0", out_valid, out_ctrl);
      else passed++;
      checks++;
      if (in_ready !== 1'b0)
         $display("FAIL reset_rdy got %b want 0", in_ready);
      else passed++;
      rst = 1'b0;
      in_valid = 1'b0;
      step("post_reset");
      checks++;
      if (in_ready !== 1'b1)
         $display("FAIL rdy_after_release got %b want 1", in_ready);
      else passed++;
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         push(CW'(i));
         step("stream");
      end
      in_valid = 1'b0;
      repeat (2) step("stream_drain");
   endtask

   task automatic test_backpressure();
      int n;
      out_ready = 1'b0;
      push(12'h0AA); step("bp_a");
      push(12'h0BB); step("bp_b");
      push(12'h0CC);
      repeat (3) step("bp_hold");
      out_ready = 1'b1;
      n = 0;
      last_acc = 1'b0;
      while (!last_acc && n < 10) begin
         step("bp_release");
         n++;
      end
      checks++;
      if (!last_acc)
         $display("FAIL bp_c_accept got timeout want accepted");
      else passed++;
      in_valid = 1'b0;
      repeat (3) step("bp_drain");
   endtask

   task automatic test_flush_two();
      out_ready = 1'b0;
      push(12'h0AA); step("fl2_a");
      push(12'h0BB); step("fl2_b");
      push(12'h0DD);
      flush = 1'b1;
      step("fl2_flush");
      flush = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (out_data !== '0)
         $display("FAIL fl2_data got %h want 0", out_data);
      else passed++;
      step("fl2_after");
   endtask

   task automatic test_flush_out();
      out_ready = 1'b0;
      push(12'h0AA); step("flo_a");
      in_valid = 1'b0;
      out_ready = 1'b1;
      flush = 1'b1;
      step("flo_flush");
      flush = 1'b0;
      step("flo_after");
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      push(12'h0AA); step("ar_a");
      push(12'h0BB); step("ar_b");
      in_valid = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b0)
         $display("FAIL async_rst got v=%b c=%h r=%b want 0 0 0",
                  out_valid, out_ctrl, in_ready);
      else passed++;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      step("ar_release");
      step("ar_idle");
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_ctrl   = CW'($urandom());
         in_data   = rdata();
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 19) == 0);
         step("random");
      end
      in_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b1;
      repeat (3) step("rand_drain");
   endtask

`ifdef PL_REG_STATS_EN
   task automatic test_stats();
      test_reset();
      out_ready = 1'b0;
      push(12'h011); step("st_a");
      in_valid = 1'b0;
      repeat (5) step("st_stall");
      out_ready = 1'b1;
      flush = 1'b1; step("st_fl1");
      flush = 1'b0;
      push(12'h022); step("st_b");
      in_valid = 1'b0;
      flush = 1'b1; step("st_fl2");
      flush = 1'b0;
      checks++;
      if (stall_cnt !== SW'(5) || flush_cnt !== SW'(2))
         $display("FAIL stats got s=%0d f=%0d want 5 2", stall_cnt, flush_cnt);
      else passed++;
      test_reset();
      out_ready = 1'b0;
      push(12'h033); step("sat_a");
      in_valid = 1'b0;
      repeat (6) step("sat_stall");
      checks++;
      if (s_stall_cnt !== 2'd3)
         $display("FAIL stat_sat got %0d want 3", s_stall_cnt);
      else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush_two();
      test_flush_out();
      test_async_reset();
      test_random();
`ifdef PL_REG_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
